// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// W stage (always wins) and a long-latency unit whose results are parked in
// a small FIFO until the port is idle. Tracks LLU-pending destinations for
// the hazard unit and raises stall_req when the FIFO is starved of the port.
// Optional feature macro: WB_ARB_BYPASS_EN (same-cycle LLU write when idle).
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            llu_issue,
    input  logic [4:0]      llu_issue_rd,
    input  logic            llu_valid,
    input  logic [4:0]      llu_rd,
    input  logic [XLEN-1:0] llu_data,
    output logic            llu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall_req
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, STARVED} state_e;

    logic [4:0]      rd_mem_q   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      busy_q, busy_d;
    logic [STV_W-1:0] starve_q, starve_d;
    state_e           state_q;
    logic             stall_q;

    logic       fifo_empty, push, pop, bypass, clr_en;
    logic [4:0] head_rd, clr_rd;

    assign fifo_empty = (count_q == '0);
    // Ready depends only on registered occupancy so the LLU never sees a
    // combinational path through the pipeline write enable.
    assign llu_ready  = (count_q < CNT_W'(FIFO_DEPTH));
    assign head_rd    = rd_mem_q[rd_ptr_q];

`ifdef WB_ARB_BYPASS_EN
    assign bypass = fifo_empty & ~wb_we & llu_valid & (llu_rd != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // x0 results are accepted by the handshake but never stored.
    assign push   = llu_valid & llu_ready & (llu_rd != 5'd0) & ~bypass;
    assign pop    = ~wb_we & ~fifo_empty;
    assign clr_en = pop | bypass;
    assign clr_rd = bypass ? llu_rd : head_rd;

    assign rs1_busy  = busy_q[rs1_addr];
    assign rs2_busy  = busy_q[rs2_addr];
    assign stall_req = stall_q;

    // Port grant: pipeline first, then bypass, then FIFO head, else idle.
    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (wb_we) begin
            rf_we    = 1'b1;
            rf_rd    = wb_rd;
            rf_wdata = wb_data;
        end else if (bypass) begin
            rf_we    = 1'b1;
            rf_rd    = llu_rd;
            rf_wdata = llu_data;
        end else if (!fifo_empty) begin
            rf_we    = 1'b1;
            rf_rd    = head_rd;
            rf_wdata = data_mem_q[rd_ptr_q];
        end
        if (!rst_n) rf_we = 1'b0;
    end

    // Next-state for occupancy, pending-rd scoreboard and starve counter.
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        // A new issue to the same rd on the clearing edge must stay pending.
        if (llu_issue && (llu_issue_rd != 5'd0)) busy_d[llu_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;

        starve_d = starve_q;
        if (pop || fifo_empty)                               starve_d = '0;
        else if (wb_we && (starve_q != STV_W'(STARVE_LIMIT))) starve_d = starve_q + STV_W'(1);
    end

    // FIFO payload storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= llu_rd;
            data_mem_q[wr_ptr_q] <= llu_data;
        end
    end

    // Control state: pointers, count, scoreboard, starve counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            starve_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    // Starvation FSM with registered stall request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            stall_q <= 1'b0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (starve_d == STV_W'(STARVE_LIMIT)) begin
                        state_q <= STARVED;
                        stall_q <= 1'b1;
                    end
                end
                STARVED: begin
                    if (pop || fifo_empty) begin
                        state_q <= NORMAL;
                        stall_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= NORMAL;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenario tasks plus a randomized run against
// a queue-based reference model of the write-port arbiter.
module tb_wb_port_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_we = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            llu_issue = 1'b0;
    logic [4:0]      llu_issue_rd = '0;
    logic            llu_valid = 1'b0;
    logic [4:0]      llu_rd = '0;
    logic [XLEN-1:0] llu_data = '0;
    logic            llu_ready;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      rs1_addr = '0;
    logic [4:0]      rs2_addr = '0;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            stall_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .llu_issue(llu_issue), .llu_issue_rd(llu_issue_rd),
        .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data),
        .llu_ready(llu_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .stall_req(stall_req)
    );

    task automatic idle_inputs();
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        llu_issue = 1'b0; llu_issue_rd = '0;
        llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({llu_ready, rf_we, stall_req, rs1_busy} !== 4'b1000) begin
            errors++; $display("FAIL reset_init: got %b expected 1000", {llu_ready, rf_we, stall_req, rs1_busy});
        end
        @(negedge clk); rst_n = 1'b1;
        // two buffered results plus a pending rd=9
        @(negedge clk);
        wb_we = 1'b1; wb_rd = 5'd1; llu_issue = 1'b1; llu_issue_rd = 5'd9;
        llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'hA;
        @(negedge clk);
        llu_issue = 1'b0; llu_rd = 5'd10; llu_data = 32'hB;
        @(negedge clk);
        llu_valid = 1'b0; rs1_addr = 5'd9;
        #1;
        checks++;
        if ({llu_ready, rs1_busy} !== 2'b01) begin
            errors++; $display("FAIL reset_prefill: got %b expected 01", {llu_ready, rs1_busy});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({llu_ready, rf_we, stall_req, rs1_busy} !== 4'b1000) begin
            errors++; $display("FAIL reset_async: got %b expected 1000", {llu_ready, rf_we, stall_req, rs1_busy});
        end
        @(negedge clk);
        rst_n = 1'b1; wb_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rf_we !== 1'b0) begin
                errors++; $display("FAIL reset_discard cyc%0d: rf_we got %b expected 0", i, rf_we);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        @(negedge clk);
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h22;
        @(negedge clk);
        llu_valid = 1'b0; wb_rd = 5'd5; wb_data = 32'h11;
        #1;
        checks++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'h11}) begin
            errors++; $display("FAIL priority_wb: got %b/%0d/%h expected 1/5/11", rf_we, rf_rd, rf_wdata);
        end
        @(negedge clk);
        wb_we = 1'b0;
        #1;
        checks++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd7, 32'h22}) begin
            errors++; $display("FAIL priority_llu: got %b/%0d/%h expected 1/7/22", rf_we, rf_rd, rf_wdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rf_we, rf_rd, rf_wdata} !== 38'd0) begin
            errors++; $display("FAIL priority_idle: got %b/%0d/%h expected 0/0/0", rf_we, rf_rd, rf_wdata);
        end
        idle_inputs();
    endtask

    task automatic test_full();
        logic [4:0]  exp_rd [3];
        logic [31:0] exp_d  [3];
        exp_rd = '{5'd11, 5'd12, 5'd13};
        exp_d  = '{32'hD1, 32'hD2, 32'hD3};
        @(negedge clk);
        wb_we = 1'b1; wb_rd = 5'd2;
        for (int i = 0; i < 2; i++) begin
            llu_valid = 1'b1; llu_rd = exp_rd[i]; llu_data = exp_d[i];
            #1;
            checks++;
            if (llu_ready !== 1'b1) begin
                errors++; $display("FAIL full_fill%0d: llu_ready got %b expected 1", i, llu_ready);
            end
            @(negedge clk);
        end
        llu_rd = exp_rd[2]; llu_data = exp_d[2];
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (llu_ready !== 1'b0) begin
                errors++; $display("FAIL full_hold%0d: llu_ready got %b expected 0", i, llu_ready);
            end
            @(negedge clk);
        end
        wb_we = 1'b0;
        #1;
        checks++;
        if ({llu_ready, rf_we, rf_rd, rf_wdata} !== {1'b0, 1'b1, exp_rd[0], exp_d[0]}) begin
            errors++; $display("FAIL full_pop: got %b/%b/%0d/%h expected 0/1/11/d1", llu_ready, rf_we, rf_rd, rf_wdata);
        end
        @(negedge clk);
        wb_we = 1'b1;
        #1;
        checks++;
        if (llu_ready !== 1'b1) begin
            errors++; $display("FAIL full_reopen: llu_ready got %b expected 1", llu_ready);
        end
        @(negedge clk);
        llu_valid = 1'b0; wb_we = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #1;
            checks++;
            if ({rf_we, rf_rd, rf_wdata} !== {1'b1, exp_rd[i], exp_d[i]}) begin
                errors++; $display("FAIL full_drain%0d: got %b/%0d/%h expected 1/%0d/%h", i, rf_we, rf_rd, rf_wdata, exp_rd[i], exp_d[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL full_empty: rf_we got %b expected 0", rf_we);
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        @(negedge clk);
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        llu_valid = 1'b1; llu_rd = 5'd20; llu_data = 32'h2020;
        @(negedge clk);
        llu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (stall_req !== 1'b0) begin
                errors++; $display("FAIL starve_pre%0d: stall_req got %b expected 0", i, stall_req);
            end
            @(negedge clk);
        end
        // pipeline ignores the stall request for one cycle and keeps the port
        #1;
        checks++;
        if ({stall_req, rf_we, rf_rd} !== {1'b1, 1'b1, 5'd4}) begin
            errors++; $display("FAIL starve_ignored: got %b/%b/%0d expected 1/1/4", stall_req, rf_we, rf_rd);
        end
        @(negedge clk);
        wb_we = 1'b0;
        #1;
        checks++;
        if ({stall_req, rf_we, rf_rd, rf_wdata} !== {1'b1, 1'b1, 5'd20, 32'h2020}) begin
            errors++; $display("FAIL starve_drain: got %b/%b/%0d/%h expected 1/1/20/2020", stall_req, rf_we, rf_rd, rf_wdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({stall_req, rf_we} !== 2'b00) begin
            errors++; $display("FAIL starve_release: got %b expected 00", {stall_req, rf_we});
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        llu_issue = 1'b1; llu_issue_rd = 5'd9; rs1_addr = 5'd9; rs2_addr = 5'd8;
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++; $display("FAIL sb_before_set: rs1_busy got %b expected 0", rs1_busy);
        end
        @(negedge clk);
        llu_issue = 1'b0;
        #1;
        checks++;
        if ({rs1_busy, rs2_busy} !== 2'b10) begin
            errors++; $display("FAIL sb_set: got %b expected 10", {rs1_busy, rs2_busy});
        end
        // result through the FIFO, written on the next idle cycle
        @(negedge clk);
        wb_we = 1'b1; wb_rd = 5'd1; llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'h99;
        @(negedge clk);
        wb_we = 1'b0; llu_valid = 1'b0;
        #1;
        checks++;
        if ({rf_we, rf_rd, rs1_busy} !== {1'b1, 5'd9, 1'b1}) begin
            errors++; $display("FAIL sb_writing: got %b/%0d/%b expected 1/9/1", rf_we, rf_rd, rs1_busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++; $display("FAIL sb_cleared: rs1_busy got %b expected 0", rs1_busy);
        end
        // set and clear of rd=9 on the same edge
        @(negedge clk);
        llu_issue = 1'b1; llu_issue_rd = 5'd9;
        wb_we = 1'b1; llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'h98;
        @(negedge clk);
        llu_valid = 1'b0; wb_we = 1'b0;
        #1;
        checks++;
        if ({rf_we, rf_rd} !== {1'b1, 5'd9}) begin
            errors++; $display("FAIL sb_same_edge_pop: got %b/%0d expected 1/9", rf_we, rf_rd);
        end
        @(negedge clk);
        llu_issue = 1'b0;
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins: rs1_busy got %b expected 1", rs1_busy);
        end
        // x0 issue never becomes pending
        @(negedge clk);
        llu_issue = 1'b1; llu_issue_rd = 5'd0; rs2_addr = 5'd0;
        @(negedge clk);
        llu_issue = 1'b0;
        #1;
        checks++;
        if (rs2_busy !== 1'b0) begin
            errors++; $display("FAIL sb_x0: rs2_busy got %b expected 0", rs2_busy);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        llu_valid = 1'b1; llu_rd = 5'd3; llu_data = 32'hAB;
        #1;
`ifdef WB_ARB_BYPASS_EN
        checks++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd3, 32'hAB}) begin
            errors++; $display("FAIL bypass_same: got %b/%0d/%h expected 1/3/ab", rf_we, rf_rd, rf_wdata);
        end
        @(negedge clk);
        llu_valid = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL bypass_nopush: rf_we got %b expected 0", rf_we);
        end
`else
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL nobypass_same: rf_we got %b expected 0", rf_we);
        end
        @(negedge clk);
        llu_valid = 1'b0;
        #1;
        checks++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd3, 32'hAB}) begin
            errors++; $display("FAIL nobypass_next: got %b/%0d/%h expected 1/3/ab", rf_we, rf_rd, rf_wdata);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_random();
        logic [36:0] mq[$];
        bit          mbusy[32];
        int          mstarve;
        bit          mstalled;
        int          wb_pct;
        logic [37:0] exp_rf;
        logic [36:0] head;
        bit          exp_ready, byp, popped, was_empty;
        apply_reset();
        mq.delete();
        foreach (mbusy[k]) mbusy[k] = 1'b0;
        mstarve = 0; mstalled = 1'b0; wb_pct = 50;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 40 == 0) wb_pct = (cyc % 80 == 0) ? 90 : 40;
            @(negedge clk);
            wb_we        = ($urandom_range(0, 99) < wb_pct);
            wb_rd        = 5'($urandom);
            wb_data      = $urandom;
            llu_issue    = ($urandom_range(0, 3) == 0);
            llu_issue_rd = 5'($urandom);
            llu_valid    = ($urandom_range(0, 2) == 0);
            llu_rd       = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            llu_data     = $urandom;
            rs1_addr     = 5'($urandom);
            rs2_addr     = 5'($urandom);
            #1;
            exp_ready = (mq.size() < DEPTH);
            byp = 1'b0;
`ifdef WB_ARB_BYPASS_EN
            byp = (mq.size() == 0) && !wb_we && llu_valid && (llu_rd != 5'd0);
`endif
            if (wb_we)              exp_rf = {1'b1, wb_rd, wb_data};
            else if (byp)           exp_rf = {1'b1, llu_rd, llu_data};
            else if (mq.size() > 0) exp_rf = {1'b1, mq[0]};
            else                    exp_rf = '0;
            checks++;
            if ({rf_we, rf_rd, rf_wdata} !== exp_rf) begin
                errors++; $display("FAIL rand_rf cyc%0d: got %h expected %h", cyc, {rf_we, rf_rd, rf_wdata}, exp_rf);
            end
            checks++;
            if ({llu_ready, stall_req} !== {exp_ready, mstalled}) begin
                errors++; $display("FAIL rand_ctl cyc%0d: ready/stall got %b expected %b", cyc, {llu_ready, stall_req}, {exp_ready, mstalled});
            end
            checks++;
            if ({rs1_busy, rs2_busy} !== {mbusy[rs1_addr], mbusy[rs2_addr]}) begin
                errors++; $display("FAIL rand_busy cyc%0d: got %b expected %b", cyc, {rs1_busy, rs2_busy}, {mbusy[rs1_addr], mbusy[rs2_addr]});
            end
            // advance the model across the coming rising edge
            was_empty = (mq.size() == 0);
            popped    = !wb_we && !was_empty;
            if (popped) begin
                head = mq.pop_front();
                mbusy[head[36:32]] = 1'b0;
            end
            if (byp) mbusy[llu_rd] = 1'b0;
            if (llu_issue && llu_issue_rd != 5'd0) mbusy[llu_issue_rd] = 1'b1;
            if (llu_valid && exp_ready && llu_rd != 5'd0 && !byp) mq.push_back({llu_rd, llu_data});
            if (popped || was_empty)         mstarve = 0;
            else if (wb_we && mstarve < LIMIT) mstarve++;
            if (!mstalled && mstarve == LIMIT)             mstalled = 1'b1;
            else if (mstalled && (popped || was_empty))    mstalled = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_priority();
        test_full();
        test_starvation();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (W stage) and a long-latency unit (LLU, e.g. multi-cycle mul/div). LLU results are buffered in a small FIFO and written only in cycles the pipeline leaves the port idle. A starvation FSM requests a pipeline bubble when the FIFO is not draining. A pending-rd scoreboard tells the hazard unit which registers await LLU results.

Parameters:
XLEN, 32, data width
FIFO_DEPTH, 2, LLU result buffer entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive pipeline-granted cycles with FIFO non-empty before stall_req

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
wb_we  in  1  pipeline W-stage write enable
wb_rd  in  5  pipeline destination register
wb_data  in  XLEN  pipeline writeback value
llu_issue  in  1  LLU accepted an instruction this cycle
llu_issue_rd  in  5  destination of issued LLU instruction
llu_valid  in  1  LLU result valid
llu_rd  in  5  LLU result destination
llu_data  in  XLEN  LLU result value
llu_ready  out  1  arbiter accepts LLU result
rf_we  out  1  register-file write enable
rf_rd  out  5  register-file write address
rf_wdata  out  XLEN  register-file write data
rs1_addr  in  5  hazard-unit query 1
rs2_addr  in  5  hazard-unit query 2
rs1_busy  out  1  rs1_addr awaits LLU writeback
rs2_busy  out  1  rs2_addr awaits LLU writeback
stall_req  out  1  request W-stage bubble

Behaviour:
- Reset (rst_n low, async): FIFO empty, scoreboard all 0, starve counter 0, FSM NORMAL, stall_req 0; rf_we forced 0 while rst_n low. Reset mid-operation discards buffered results.
- Grant, combinational, same cycle: wb_we=1 -> rf_* = wb_*; else FIFO non-empty -> rf_* = FIFO head, head popped at clock edge; else rf_we=0, rf_rd=0, rf_wdata=0.
- wb_we with wb_rd=0 still granted (pipeline owns port that cycle); rf_we passes through, register file ignores x0.
- Handshake: llu_ready = (count < FIFO_DEPTH), registered-state only, no dependence on same-cycle pop. Transfer on llu_valid & llu_ready. Push and pop in same cycle legal; count unchanged.
- llu_rd=0 transfers are accepted and dropped (no push).
- Minimum LLU latency result->rf write: 1 cycle (pushed at edge N, written cycle N+1 if port free).
- Scoreboard busy[31:1]: set on llu_issue for llu_issue_rd!=0; cleared when FIFO head for that rd is written to rf. Simultaneous set and clear of same rd: set wins. busy[0] always 0. rsN_busy combinational lookups.
- Hazard unit guarantees no pipeline write to a busy rd; arbiter does not check ordering.
- Starve counter: increments each cycle with wb_we=1 and FIFO non-empty; clears on any FIFO pop or when FIFO empty; saturates at STARVE_LIMIT.
- FSM NORMAL -> STARVED on edge where counter reaches STARVE_LIMIT; stall_req=1 (registered) in STARVED. STARVED -> NORMAL on edge after a FIFO pop, or FIFO empty. If pipeline ignores stall_req, pipeline still wins the port.
- FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Optional Feature:
WB_ARB_BYPASS_EN: when defined, if FIFO empty and wb_we=0 and llu_valid=1 with llu_rd!=0, LLU result written to rf in the same cycle without being pushed, scoreboard clear same edge. When undefined, all LLU results go through FIFO (1-cycle minimum latency).

Test Plan:
- Reset: rst_n low mid-stream with 2 results buffered -> llu_ready=1, rf_we=0, stall_req=0, rs1_busy=0 immediately; nothing written after release.
- Priority: wb_we=1 rd=5 data=0x11 and FIFO head rd=7 data=0x22 -> cycle 0 rf writes x5=0x11; next idle cycle rf writes x7=0x22.
- Full: 2 results pushed, wb_we held 1 -> llu_ready=0; third result held by LLU; after one pop llu_ready=1 next cycle.
- Starvation: FIFO non-empty, wb_we=1 for 4 cycles -> stall_req=1 on 5th cycle; bench drops wb_we -> head written, stall_req=0 following cycle.
- Scoreboard: llu_issue rd=9, rs1_addr=9 -> rs1_busy=1 next cycle; llu result rd=9 written -> rs1_busy=0 after write edge; issue+clear of rd=9 same edge -> stays 1; llu_issue rd=0 -> busy never set.
- Bypass (macro on): FIFO empty, wb_we=0, llu_valid rd=3 data=0xAB -> rf_we=1 x3=0xAB same cycle; macro off -> written one cycle later.
